mc_control_unit: RTL
====================

Name: mc_control_unit

Overview:
- Multicycle MIPS control unit that sequences the shared-ALU/shared-memory datapath.
- Decodes `op`/`funct` from the instruction register and walks a Moore FSM, one state per cycle.
- Drives every datapath mux select and write enable, and derives `pc_en` from the branch condition.
- Sits beside the datapath; it is the only source of its control signals.

Parameters:
- TRAP_ILLEGAL, 1, 1 = unsupported op/funct enters sticky ILLEGAL state; 0 = treated as NOP (back to FETCH).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- i_or_d  out  1  memory address select (0 = pc, 1 = alu_out)
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  register-file write address select (1 = rd, 0 = rt)
- mem_to_reg  out  1  register-file write data select (1 = data, 0 = alu_out)
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A select (0 = pc, 1 = a)
- alu_src_b  out  2  ALU B select (00 = b, 01 = 4, 10 = imm, 11 = imm<<2)
- alu_control  out  3  ALU function
- pc_src  out  2  next-PC select (00 = alu_result, 01 = alu_out, 10 = jump)
- pc_en  out  1  PC load enable
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- halted  out  1  high while in ILLEGAL

Behaviour:
- Single clock domain. Reset is asynchronous and active-high: the state register clears to FETCH immediately.
- While reset is high, `mem_write`, `ir_write`, `reg_write`, `pc_en` and `instr_done` are forced to 0. All other outputs take their FETCH values; `halted` is 0.
- Outputs are a pure Moore decode of state. The only exception is `pc_en = pc_write | (branch & zero)`. Any signal not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- alu_op encoding: 00 = add (010), 01 = sub (110), 10 = from funct.
- Funct mapping: add 010, sub 110, and 000, or 001, slt 111.
- States, outputs and transitions:
  - FETCH: ir_write, pc_write, alu_src_b = 01, alu_op = 00. Next: DECODE.
  - DECODE: alu_src_b = 11, alu_op = 00 (branch target into alu_out). Next, by op:
    - lw/sw: MEMADR
    - R-type: EXECUTE
    - beq: BRANCH
    - addi: ADDIEX
    - j: JUMP
    - unsupported op, or R-type with unsupported funct: ILLEGAL if TRAP_ILLEGAL, else FETCH.
  - MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: i_or_d = 1. Next: MEMWB.
  - MEMWB: mem_to_reg = 1, reg_write, instr_done. Next: FETCH.
  - MEMWRITE: i_or_d = 1, mem_write, instr_done. Next: FETCH.
  - EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next: ALUWB.
  - ALUWB: reg_dst = 1, reg_write, instr_done. Next: FETCH.
  - BRANCH: alu_src_a = 1, alu_op = 01, pc_src = 01, branch, instr_done. Next: FETCH.
  - ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: ADDIWB.
  - ADDIWB: reg_write, instr_done. Next: FETCH.
  - JUMP: pc_src = 10, pc_write, instr_done. Next: FETCH.
  - ILLEGAL: halted = 1, all enables 0. Stays until reset.
- Instruction latency in cycles, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- beq with `zero` = 0: `pc_en` = 0 in BRANCH; the PC keeps pc+4 written in FETCH.
- `zero` is sampled only in BRANCH. `op`/`funct` are used in DECODE, MEMADR and EXECUTE; the IR is stable there because `ir_write` is high only in FETCH.
- Reset asserted mid-instruction aborts it. No write enable fires after reset asserts, and the first FETCH occurs on the first clock edge after reset deasserts.
- Unused encodings: alu_op 11 decodes to 010. State-register encodings not listed above return to FETCH on the next cycle.

Decomposition:
- Shared package `mips_pkg`:
  - state enum
  - OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_ADDI/OP_J
  - FUNCT_ADD/SUB/AND/OR/SLT
  - ALU_ADD/SUB/AND/OR/SLT codes
  - ALUOP_* and PCSRC_*/SRCB_* select constants
- One sub-module: `alu_decoder` (alu_op, funct -> alu_control), purely combinational. It is reused by any future pipelined control.

Test Plan:
- Reset pulse mid-MEMREAD -> state returns to FETCH asynchronously; mem_write, ir_write, reg_write and pc_en stay 0 while reset is high; ir_write = 1 and pc_en = 1 in the first cycle after deassert.
- op = 100011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write = 1 with mem_to_reg = 1 in cycle 5 only; instr_done pulses once.
- op = 000000, funct = 100010 -> alu_control = 110 in EXECUTE; ALUWB with reg_dst = 1; 4 cycles total. Repeat with funct = 101010 -> alu_control = 111.
- op = 000100: with zero = 1 in BRANCH -> pc_en = 1, pc_src = 01; with zero = 0 -> pc_en = 0; 3 cycles each.
- op = 000010 -> JUMP with pc_src = 10, pc_en = 1; op = 101011 -> mem_write = 1 with i_or_d = 1 in cycle 4 only.
- op = 111111, TRAP_ILLEGAL = 1 -> halted = 1 from cycle 3, no enables thereafter until reset. With TRAP_ILLEGAL = 0 -> FETCH in cycle 3, instr_done never pulses.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode and
// funct fields, ALU function codes and datapath mux selects.
package mips_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECUTE  = 4'd6;
   localparam state_t S_ALUWB    = 4'd7;
   localparam state_t S_BRANCH   = 4'd8;
   localparam state_t S_ADDIEX   = 4'd9;
   localparam state_t S_ADDIWB   = 4'd10;
   localparam state_t S_JUMP     = 4'd11;
   localparam state_t S_ILLEGAL  = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   function automatic logic funct_supported(input logic [5:0] f);
      return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
             (f == FUNCT_OR)  || (f == FUNCT_SLT);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the control-unit alu_op plus the R-type funct field onto the 3-bit ALU
// function code. Purely combinational so a pipelined control can reuse it.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_control_o
);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB:   alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct_i)
               FUNCT_SUB: alu_control_o = ALU_SUB;
               FUNCT_AND: alu_control_o = ALU_AND;
               FUNCT_OR:  alu_control_o = ALU_OR;
               FUNCT_SLT: alu_control_o = ALU_SLT;
               default:   alu_control_o = ALU_ADD;
            endcase
         end
         default:     alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Moore FSM sequencing the shared-ALU/shared-memory multicycle MIPS datapath;
// one state per cycle, every mux select and write enable comes from here.
module mc_control_unit
   import mips_pkg::*;
#(
   parameter logic TRAP_ILLEGAL = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       i_or_d,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       instr_done,
   output logic       halted
);

   state_t     state_q, state_d;
   state_t     bad_next;
   logic [1:0] alu_op;
   logic       mem_write_c, ir_write_c, reg_write_c, pc_write_c, branch_c, done_c;

   assign bad_next = TRAP_ILLEGAL ? S_ILLEGAL : S_FETCH;

   // NOTE: state registers update with non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = funct_supported(funct) ? S_EXECUTE : bad_next;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = bad_next;
            endcase
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: state_d = S_MEMWB;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_FETCH;
      endcase
   end

   always_comb begin
      i_or_d      = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write_c = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_B;
      alu_op      = ALUOP_ADD;
      pc_src      = PCSRC_ALU;
      pc_write_c  = 1'b0;
      branch_c    = 1'b0;
      done_c      = 1'b0;
      halted      = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            alu_src_b  = SRCB_FOUR;
         end
         S_DECODE:   alu_src_b = SRCB_IMMSH2;
         S_MEMADR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD:  i_or_d = 1'b1;
         S_MEMWB: begin
            mem_to_reg  = 1'b1;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_MEMWRITE: begin
            i_or_d      = 1'b1;
            mem_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_dst     = 1'b1;
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = PCSRC_ALUOUT;
            branch_c  = 1'b1;
            done_c    = 1'b1;
         end
         S_ADDIWB: begin
            reg_write_c = 1'b1;
            done_c      = 1'b1;
         end
         S_JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_write_c = 1'b1;
            done_c     = 1'b1;
         end
         S_ILLEGAL:  halted = 1'b1;
         default: ;
      endcase
   end

   // Enables are masked by reset so nothing is written while FETCH is forced.
   assign mem_write  = mem_write_c & ~reset;
   assign ir_write   = ir_write_c  & ~reset;
   assign reg_write  = reg_write_c & ~reset;
   assign instr_done = done_c      & ~reset;
   assign pc_en      = (pc_write_c | (branch_c & zero)) & ~reset;

   alu_decoder u_alu_decoder (
      .alu_op_i      (alu_op),
      .funct_i       (funct),
      .alu_control_o (alu_control)
   );

endmodule
